// File: rtl/key_event_decoder.sv
// Turns debounced key press/release strobes into single, double and long-press events.
// All outputs are registered; one shared timer measures hold time and the double-click gap.
module key_event_decoder #(
    parameter int unsigned LONG_CNT   = 100_000_000,
    parameter int unsigned DCLICK_CNT = 15_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_flag,
    input  logic key_state,
    output logic single_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic long_hold
);

    localparam int unsigned MAX_CNT = (LONG_CNT > DCLICK_CNT) ? LONG_CNT : DCLICK_CNT;
    localparam int unsigned CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        WAIT2  = 3'd3,
        PRESS2 = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             press_ev;
    logic             rel_ev;

    assign press_ev = key_flag & ~key_state;
    assign rel_ev   = key_flag &  key_state;

    // Release beats the long threshold and press beats the click timeout on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            single_pulse <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            long_hold    <= 1'b0;
        end else begin
            single_pulse <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_ev) begin
                        state <= PRESS1;
                        timer <= '0;
                    end
                end
                PRESS1: begin
                    if (rel_ev) begin
                        state <= WAIT2;
                        timer <= '0;
                    end else if (timer == LONG_LAST) begin
                        state      <= LONG;
                        timer      <= '0;
                        long_pulse <= 1'b1;
                        long_hold  <= 1'b1;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (rel_ev) begin
                        state     <= IDLE;
                        timer     <= '0;
                        long_hold <= 1'b0;
                    end
                end
                WAIT2: begin
                    if (press_ev) begin
                        state <= PRESS2;
                        timer <= '0;
                    end else if (timer == DCLICK_LAST) begin
                        state        <= IDLE;
                        timer        <= '0;
                        single_pulse <= 1'b1;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                PRESS2: begin
                    if (rel_ev) begin
                        state        <= IDLE;
                        timer        <= '0;
                        double_pulse <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    long_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: timestamp-based reference model feeds an
// expected-event queue that a negedge monitor drains against the DUT pulses.
module tb_key_event_decoder;

    localparam int unsigned LONG_CNT   = 20;
    localparam int unsigned DCLICK_CNT = 10;
    localparam int K_SINGLE = 0;
    localparam int K_DOUBLE = 1;
    localparam int K_LONG   = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic key_flag;
    logic key_state;
    logic single_pulse;
    logic double_pulse;
    logic long_pulse;
    logic long_hold;

    key_event_decoder #(.LONG_CNT(LONG_CNT), .DCLICK_CNT(DCLICK_CNT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_flag     (key_flag),
        .key_state    (key_state),
        .single_pulse (single_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .long_hold    (long_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int          kind;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        lvl = 1'b1;

    // Reference model: remembers when the current phase began and fires on elapsed time.
    int          phase = 0;   // 0 idle, 1 first press, 2 long held, 3 gap, 4 second press
    int unsigned t0 = 0;
    logic        m_hold = 1'b0;

    task automatic push_exp(input int kind, input int unsigned at);
        exp_t e;
        e.cyc  = at;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic model(input logic f, input logic s, input logic r);
        logic pr, rl;
        pr = f & ~s;
        rl = f & s;
        if (!r) begin
            phase  = 0;
            m_hold = 1'b0;
        end else begin
            case (phase)
                0: if (pr) begin phase = 1; t0 = cyc; end
                1: if (rl) begin
                       phase = 3; t0 = cyc;
                   end else if (cyc - t0 == LONG_CNT) begin
                       push_exp(K_LONG, cyc); phase = 2; m_hold = 1'b1;
                   end
                2: if (rl) begin phase = 0; m_hold = 1'b0; end
                3: if (pr) begin
                       phase = 4;
                   end else if (cyc - t0 == DCLICK_CNT) begin
                       push_exp(K_SINGLE, cyc); phase = 0;
                   end
                default: if (rl) begin push_exp(K_DOUBLE, cyc); phase = 0; end
            endcase
        end
    endtask

    task automatic tick(input logic f, input logic s, input logic r);
        key_flag  = f;
        key_state = s;
        reset_n   = r;
        @(posedge clk);
        cyc++;
        model(f, s, r);
        #1;
        key_flag = 1'b0;
        reset_n  = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, lvl, 1'b1);
    endtask

    task automatic do_press();
        lvl = 1'b0;
        tick(1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_release();
        lvl = 1'b1;
        tick(1'b1, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        tick(1'b0, lvl, 1'b0);
    endtask

    // Monitor: pops one expected event per observed pulse and checks the hold level.
    always @(negedge clk) begin
        if (cyc > 0) begin
            logic [2:0] p;
            p = {long_pulse, double_pulse, single_pulse};
            if ($countones(p) > 1) begin
                errors++;
                $display("FAIL onehot cyc=%0d pulses=%b required at most one", cyc, p);
            end
            for (int k = 0; k < 3; k++) begin
                if (p[k] === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse kind=%0d cyc=%0d required none", k, cyc);
                    end else if (exp_q[0].kind != k || exp_q[0].cyc != cyc) begin
                        errors++;
                        $display("FAIL pulse got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                                 k, cyc, exp_q[0].kind, exp_q[0].cyc);
                        void'(exp_q.pop_front());
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse kind=%0d required at cyc=%0d", exp_q[0].kind, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            checks++;
            if (long_hold !== m_hold) begin
                errors++;
                $display("FAIL long_hold cyc=%0d got=%b required=%b", cyc, long_hold, m_hold);
            end
        end
    end

    initial begin
        key_flag  = 1'b0;
        key_state = 1'b1;
        reset_n   = 1'b0;
        do_reset();
        do_reset();
        // Reset state
        checks++;
        if ({single_pulse, double_pulse, long_pulse, long_hold} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got=%b required=0000",
                     {single_pulse, double_pulse, long_pulse, long_hold});
        end
        idle(3);
        // Single click
        do_press(); idle(4); do_release(); idle(15);
        // Double click
        do_press(); idle(2); do_release(); idle(3); do_press(); idle(2); do_release(); idle(15);
        // Long press held 40 cycles
        do_press(); idle(39); do_release(); idle(5);
        // Release exactly at the long threshold, then single
        do_press(); idle(LONG_CNT - 1); do_release(); idle(15);
        // Press exactly at the click timeout -> double
        do_press(); idle(3); do_release(); idle(DCLICK_CNT - 1); do_press(); idle(5); do_release(); idle(5);
        // Stray release in idle, repeated press strobes while pressed
        tick(1'b1, 1'b1, 1'b1); idle(3);
        do_press(); idle(3); tick(1'b1, 1'b0, 1'b1); idle(2); tick(1'b1, 1'b0, 1'b1); idle(2);
        do_release(); idle(15);
        // Reset while long held, then while waiting for second press
        do_press(); idle(25); do_reset(); idle(5); do_release(); idle(25);
        do_press(); idle(3); do_release(); idle(4); do_reset(); idle(25);
        // Randomized activity
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2) do_reset();
            else if (r < 8) tick(1'b1, lvl, 1'b1);
            else if (lvl) do_press();
            else do_release();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(15, 30));
            else idle($urandom_range(0, 12));
        end
        if (!lvl) do_release();
        idle(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
